vfd_persist: RTL and testbench

//  Downstream of the uCOM-43 core. Samples the multiplexed VFD grid/plate outputs (ports C..I,

---
 rtl/vfd_persist_pkg.sv | 22 ++
 rtl/vfd_persist_if.sv | 27 ++
 rtl/vfd_persist_seg_accum.sv | 47 ++++
 rtl/vfd_persist.sv | 114 +++++++++++
 tb/tb_vfd_persist.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vfd_persist_pkg.sv
// vfd_persist_pkg
//   Shared definitions for the VFD persistence filter. It holds the default
//   geometry and window, the FSM state encoding, and the helper that sizes a
//   saturating counter able to hold the value WIN.
package vfd_persist_pkg;

    localparam int GRIDS_DEF  = 10;
    localparam int PLATES_DEF = 16;
    localparam int WIN_DEF    = 256;
    localparam int THRESH_DEF = 64;

    typedef enum logic {
        ACCUM   = 1'b0,
        PUBLISH = 1'b1
    } state_t;

    // A counter that saturates at win needs to represent win itself.
    function automatic int cnt_width(input int win);
        return $clog2(win + 1);
    endfunction

endpackage

// File: rtl/vfd_persist_if.sv
// vfd_persist_if
//   Groups the sampled VFD drive lines, the row-read port and the publish
//   strobe.
//   master : MCU/renderer side. It drives sample_en, grid, plate and rd_grid,
//            and receives rd_data and frame_done.
//   slave  : vfd_persist side.
interface vfd_persist_if #(
    parameter int GRIDS  = 10,
    parameter int PLATES = 16
);
    logic              sample_en;
    logic [GRIDS-1:0]  grid;
    logic [PLATES-1:0] plate;
    logic [3:0]        rd_grid;
    logic [PLATES-1:0] rd_data;
    logic              frame_done;

    modport master (
        output sample_en, grid, plate, rd_grid,
        input  rd_data, frame_done
    );

    modport slave (
        input  sample_en, grid, plate, rd_grid,
        output rd_data, frame_done
    );
endinterface

// File: rtl/vfd_persist_seg_accum.sv
// vfd_seg_accum
//   Lit-time integrator for one grid/plate cell.
//   clk, reset : system clock, asynchronous active-high reset
//   hit        : the cell is lit on a sample strobe this cycle
//   clear      : window end. The counter restarts at 0 next cycle.
//   on_bit     : (acc + hit) >= THRESH. This is combinational, so the sample
//                at the window end is included in the result.
module vfd_seg_accum
    import vfd_persist_pkg::*;
#(
    parameter int WIN    = WIN_DEF,
    parameter int THRESH = THRESH_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic hit,
    input  logic clear,
    output logic on_bit
);
    localparam int CW = cnt_width(WIN);

    logic [CW-1:0] acc_reg;
    logic [CW-1:0] acc_next;
    logic [CW:0]   sum;

    always_comb begin
        // One extra bit, so that a hit on a saturated counter cannot wrap.
        sum    = {1'b0, acc_reg} + (CW+1)'(hit);
        on_bit = (sum >= (CW+1)'(THRESH));
        if (clear) begin
            acc_next = '0;
        end else if (hit && (acc_reg != CW'(WIN))) begin
            acc_next = acc_reg + CW'(1);
        end else begin
            acc_next = acc_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

endmodule

// File: rtl/vfd_persist.sv
// vfd_persist
//   Integrates the multiplexed VFD grid/plate drive over windows of WIN
//   sample strobes. It publishes a double-buffered bitmap, which removes scan
//   flicker and ghosting.
//   clk, reset : system clock, asynchronous active-high reset
//   bus.slave  : sample_en/grid/plate are the sample inputs.
//                rd_grid -> rd_data is a registered row read (1-cycle
//                latency). A row index >= GRIDS reads as 0.
//                frame_done pulses for 1 cycle, together with the bank swap.
//   At a window end, the on-bits go into the back bank and all counters
//   clear. On the next edge (PUBLISH), the banks swap and frame_done is raised.
module vfd_persist
    import vfd_persist_pkg::*;
#(
    parameter int GRIDS  = GRIDS_DEF,
    parameter int PLATES = PLATES_DEF,
    parameter int WIN    = WIN_DEF,
    parameter int THRESH = THRESH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    vfd_persist_if.slave bus
);
    localparam int WW = $clog2(WIN);

    state_t                        state_reg, state_next;
    logic [WW-1:0]                 win_cnt_reg, win_cnt_next;
    logic                          bank_sel_reg;    // 0: bank0 is front
    logic                          frame_done_reg;
    logic [PLATES-1:0]             rd_data_reg;
    logic [PLATES-1:0]             rd_row;
    logic [GRIDS-1:0][PLATES-1:0]  bank0_reg;
    logic [GRIDS-1:0][PLATES-1:0]  bank1_reg;
    logic [GRIDS-1:0][PLATES-1:0]  on_map;
    logic                          win_end;
    logic                          publish;

    assign win_end = bus.sample_en && (win_cnt_reg == WW'(WIN - 1));

    for (genvar gi = 0; gi < GRIDS; gi++) begin : g_grid
        for (genvar pi = 0; pi < PLATES; pi++) begin : g_plate
            vfd_seg_accum #(
                .WIN    (WIN),
                .THRESH (THRESH)
            ) u_cell (
                .clk    (clk),
                .reset  (reset),
                .hit    (bus.sample_en & bus.grid[gi] & bus.plate[pi]),
                .clear  (win_end),
                .on_bit (on_map[gi][pi])
            );
        end
    end

    always_comb begin
        state_next   = state_reg;
        win_cnt_next = win_cnt_reg;
        publish      = 1'b0;
        // WIN need not be a power of two, so the wrap is explicit.
        if (bus.sample_en) begin
            win_cnt_next = win_end ? '0 : win_cnt_reg + WW'(1);
        end
        case (state_reg)
            ACCUM: begin
                if (win_end) begin
                    state_next = PUBLISH;
                end
            end
            PUBLISH: begin
                publish    = 1'b1;
                state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    // The read mux uses the pre-swap bank select. A read issued in the
    // PUBLISH cycle therefore still returns a whole row of the old frame.
    always_comb begin
        rd_row = '0;
        if (int'(bus.rd_grid) < GRIDS) begin
            rd_row = bank_sel_reg ? bank1_reg[bus.rd_grid] : bank0_reg[bus.rd_grid];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ACCUM;
            win_cnt_reg    <= '0;
            bank_sel_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            rd_data_reg    <= '0;
            bank0_reg      <= '0;
            bank1_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            win_cnt_reg    <= win_cnt_next;
            bank_sel_reg   <= bank_sel_reg ^ publish;
            frame_done_reg <= publish;
            rd_data_reg    <= rd_row;
            if (win_end) begin
                if (bank_sel_reg) begin
                    bank0_reg <= on_map;
                end else begin
                    bank1_reg <= on_map;
                end
            end
        end
    end

    assign bus.rd_data    = rd_data_reg;
    assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_vfd_persist.sv
module tb_vfd_persist;
    localparam int G   = 10;
    localparam int P   = 16;
    localparam int WIN = 256;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vfd_persist_if #(.GRIDS(G), .PLATES(P)) bus_a ();
    vfd_persist_if #(.GRIDS(G), .PLATES(P)) bus_b ();

    // Two instances see identical stimulus and differ only in THRESH.
    assign bus_b.sample_en = bus_a.sample_en;
    assign bus_b.grid      = bus_a.grid;
    assign bus_b.plate     = bus_a.plate;
    assign bus_b.rd_grid   = bus_a.rd_grid;

    vfd_persist #(.GRIDS(G), .PLATES(P), .WIN(WIN), .THRESH(64)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    vfd_persist #(.GRIDS(G), .PLATES(P), .WIN(WIN), .THRESH(20)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    // ---------------- reference model: per-cell lit counts per window ----------
    int              th [2] = '{64, 20};
    int              cnt [G][P];
    int              nsamp;
    bit              pend;
    logic [P-1:0]    pend_map [2][G];
    logic [P-1:0]    front [2][G];

    int    n_cmp = 0;
    int    n_bad = 0;
    string phase = "init";
    logic  last_fd;
    logic [P-1:0] last_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL [%s] %s: got %h expected %h", phase, name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int gv = 0; gv < G; gv++) begin
            for (int pv = 0; pv < P; pv++) cnt[gv][pv] = 0;
            for (int d = 0; d < 2; d++) begin
                front[d][gv]    = '0;
                pend_map[d][gv] = '0;
            end
        end
        nsamp = 0;
        pend  = 0;
    endtask

    // Apply one clock with the given inputs, advance the model, and compare
    // both DUTs.
    task automatic cycle(input logic en, input logic [G-1:0] gin,
                         input logic [P-1:0] pin, input logic [3:0] rg);
        logic [P-1:0] exp_rd [2];
        logic         exp_fd;
        bus_a.sample_en = en;
        bus_a.grid      = gin;
        bus_a.plate     = pin;
        bus_a.rd_grid   = rg;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_rd[d] = '0;
            if (int'(rg) < G) exp_rd[d] = front[d][rg];
        end
        exp_fd = pend;
        if (pend) begin
            front = pend_map;
            pend  = 0;
        end
        if (en) begin
            for (int gv = 0; gv < G; gv++)
                for (int pv = 0; pv < P; pv++)
                    if (gin[gv] && pin[pv] && cnt[gv][pv] < WIN) cnt[gv][pv]++;
            nsamp++;
            if (nsamp == WIN) begin
                for (int d = 0; d < 2; d++)
                    for (int gv = 0; gv < G; gv++)
                        for (int pv = 0; pv < P; pv++)
                            pend_map[d][gv][pv] = (cnt[gv][pv] >= th[d]);
                for (int gv = 0; gv < G; gv++)
                    for (int pv = 0; pv < P; pv++) cnt[gv][pv] = 0;
                nsamp = 0;
                pend  = 1;
            end
        end
        check("rd_data_a", 32'(bus_a.rd_data), 32'(exp_rd[0]));
        check("rd_data_b", 32'(bus_b.rd_data), 32'(exp_rd[1]));
        check("frame_done_a", 32'(bus_a.frame_done), 32'(exp_fd));
        check("frame_done_b", 32'(bus_b.frame_done), 32'(exp_fd));
        last_fd = bus_a.frame_done;
        last_rd = bus_a.rd_data;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        bus_a.sample_en = 1'b0;
        bus_a.grid      = '0;
        bus_a.plate     = '0;
        bus_a.rd_grid   = '0;
        #1;
        check("async_rd_data_a", 32'(bus_a.rd_data), 32'h0);
        check("async_frame_done_a", 32'(bus_a.frame_done), 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("post_reset_rd_data_b", 32'(bus_b.rd_data), 32'h0);
        check("post_reset_frame_done_b", 32'(bus_b.frame_done), 32'h0);
    endtask

    // Let a pending publish complete, then read every row and compare it with
    // table constants.
    task automatic read_rows(input logic [G-1:0] lit_rows,
                             input logic [P-1:0] exp_a, input logic [P-1:0] exp_b);
        cycle(1'b0, '0, '0, 4'd0);
        for (int r = 0; r < G; r++) begin
            cycle(1'b0, '0, '0, 4'(r));
            check($sformatf("row%0d_a", r), 32'(bus_a.rd_data), lit_rows[r] ? 32'(exp_a) : 32'h0);
            check($sformatf("row%0d_b", r), 32'(bus_b.rd_data), lit_rows[r] ? 32'(exp_b) : 32'h0);
        end
    endtask

    typedef struct {
        logic [G-1:0] grid;
        bit           rotate;
        logic [P-1:0] plate;
        int           lit;
        logic [P-1:0] exp_a;   // THRESH=64
        logic [P-1:0] exp_b;   // THRESH=20
    } vec_t;
    vec_t tbl [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int           fd_cnt;
        int           fd_idx;
        int           fd_at [$];
        int           c_fd;
        int           c_sw;
        bit           torn;
        logic [G-1:0] one;
        logic [G-1:0] gv;
        logic [G-1:0] gmask;
        logic [P-1:0] pmask;
        logic [G-1:0] lit_rows;

        tbl[0] = '{10'h000, 1'b0, 16'h0000, 0,   16'h0000, 16'h0000};
        tbl[1] = '{10'h001, 1'b0, 16'h0001, 64,  16'h0001, 16'h0001};
        tbl[2] = '{10'h001, 1'b0, 16'h0001, 63,  16'h0000, 16'h0001};
        tbl[3] = '{10'h000, 1'b1, 16'hFFFF, 256, 16'h0000, 16'hFFFF};
        tbl[4] = '{10'h3FF, 1'b0, 16'hA5A5, 256, 16'hA5A5, 16'hA5A5};
        tbl[5] = '{10'h204, 1'b0, 16'h8001, 20,  16'h0000, 16'h8001};
        tbl[6] = '{10'h010, 1'b0, 16'h00F0, 19,  16'h0000, 16'h0000};
        one = 1;

        // 1: reset, then 300 idle strobes. Expect a single publish at strobe 256.
        phase = "reset_idle";
        model_reset();
        do_reset();
        fd_cnt = 0;
        fd_idx = 0;
        for (int k = 1; k <= 300; k++) begin
            cycle(1'b1, '0, '0, 4'($urandom_range(0, 15)));
            if (last_fd) begin fd_cnt++; fd_idx = k; end
        end
        check("idle_fd_count", 32'(fd_cnt), 32'd1);
        check("idle_fd_strobe", 32'(fd_idx), 32'd257);
        read_rows('1, '0, '0);
        $display("reset_idle: 300 strobes, frame_done count %0d at %0d", fd_cnt, fd_idx);

        // 2/3: table of single-window vectors.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            phase = $sformatf("vec%0d", i);
            for (int k = 0; k < WIN; k++) begin
                gv = tbl[i].rotate ? (one << (k % G)) : tbl[i].grid;
                if (k < tbl[i].lit) cycle(1'b1, gv, tbl[i].plate, 4'($urandom_range(0, 15)));
                else                cycle(1'b1, '0, '0, 4'($urandom_range(0, 15)));
            end
            lit_rows = tbl[i].rotate ? '1 : tbl[i].grid;
            read_rows(lit_rows, tbl[i].exp_a, tbl[i].exp_b);
            $display("vec%0d: grid %h plate %h lit %0d -> a %h b %h",
                     i, tbl[i].grid, tbl[i].plate, tbl[i].lit, tbl[i].exp_a, tbl[i].exp_b);
        end

        // 4: 1000 saturating strobes. Expect publishes at 256, 512 and 768.
        phase = "saturate";
        fd_at = {};
        for (int k = 1; k <= 1000; k++) begin
            cycle(1'b1, 10'h3FF, 16'hA5A5, 4'($urandom_range(0, 15)));
            if (last_fd) fd_at.push_back(k);
        end
        check("sat_fd_count", 32'(fd_at.size()), 32'd3);
        for (int i = 0; i < fd_at.size() && i < 3; i++)
            check($sformatf("sat_fd%0d_strobe", i), 32'(fd_at[i]), 32'(256 * (i + 1) + 1));
        read_rows('1, 16'hA5A5, 16'hA5A5);
        $display("saturate: 1000 strobes, %0d publishes", fd_at.size());

        // 5: reset at strobe 200 of a lit window.
        phase = "mid_reset";
        for (int k = 0; k < 24 + 200; k++)
            cycle(1'b1, 10'h3FF, 16'h1234, 4'($urandom_range(0, 15)));
        do_reset();
        read_rows('1, '0, '0);
        fd_cnt = 0;
        for (int k = 1; k <= 255; k++) begin
            cycle(1'b1, 10'h3FF, 16'h1234, 4'd3);
            if (last_fd) fd_cnt++;
        end
        cycle(1'b1, 10'h3FF, 16'h1234, 4'd3);
        if (last_fd) fd_cnt++;
        check("mid_reset_no_early_fd", 32'(fd_cnt), 32'd0);
        cycle(1'b0, '0, '0, 4'd3);
        check("mid_reset_fd_at_256", 32'(last_fd), 32'd1);
        read_rows('1, 16'h1234, 16'h1234);
        $display("mid_reset: no publish before 256 strobes after release");

        // 6: poll row 3 across a publish.
        phase = "poll";
        c_fd = -1;
        c_sw = -1;
        torn = 0;
        for (int k = 1; k <= WIN + 4; k++) begin
            if (k <= WIN) cycle(1'b1, 10'h3FF, 16'h0F0F, 4'd3);
            else          cycle(1'b0, '0, '0, 4'd3);
            if (last_fd && c_fd < 0) c_fd = k;
            if (last_rd == 16'h0F0F && c_sw < 0) c_sw = k;
            if (last_rd != 16'h0F0F && last_rd != 16'h1234) torn = 1;
            if (c_sw >= 0 && last_rd != 16'h0F0F) torn = 1;
        end
        check("poll_fd_cycle", 32'(c_fd), 32'(WIN + 1));
        check("poll_switch_cycle", 32'(c_sw), 32'(c_fd + 1));
        check("poll_no_torn", 32'(torn), 32'd0);
        cycle(1'b0, '0, '0, 4'd12);
        check("rd_grid12_a", 32'(bus_a.rd_data), 32'h0);
        cycle(1'b0, '0, '0, 4'd15);
        check("rd_grid15_b", 32'(bus_b.rd_data), 32'h0);
        $display("poll: frame_done at %0d, row3 switched at %0d", c_fd, c_sw);

        // Random traffic against the model.
        phase = "random";
        gmask = '0;
        pmask = '0;
        fd_cnt = 0;
        for (int k = 0; k < 2000; k++) begin
            if (k % 300 == 0) begin
                gmask = G'($urandom);
                pmask = P'($urandom);
            end
            cycle(($urandom_range(0, 3) != 0), G'($urandom) & gmask,
                  P'($urandom) | pmask, 4'($urandom_range(0, 15)));
            if (last_fd) fd_cnt++;
        end
        $display("random: 2000 cycles, %0d publishes", fd_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
